// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
`timescale 1ns/1ps
interface mem_access_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: formats stores, extends loads, and stalls the pipeline until the
// data-memory bus completes the access.
`timescale 1ns/1ps
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wem,
    input  logic [2:0]            opm,
    input  logic                  mem_wem,
    input  logic [4:0]            rdm,
    input  logic [ADDR_WIDTH-1:0] pcnm,
    input  logic [DATA_WIDTH-1:0] alu_resultm,
    input  logic [DATA_WIDTH-1:0] rd2_turem,
    input  logic [1:0]            wb_ctrm,
    mem_access_stage_if.master    dmem,
    output logic                  stall_mem,
    output logic                  misalign_exc,
    output logic                  reg_wew,
    output logic [4:0]            rdw,
    output logic [ADDR_WIDTH-1:0] pcnw,
    output logic [DATA_WIDTH-1:0] alu_resultw,
    output logic [DATA_WIDTH-1:0] mem_rdataw,
    output logic [1:0]            wb_ctrw
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_next;
    logic                  load, access, misaligned, start;
    logic [1:0]            offset;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic [2:0]            op_q;
    logic [1:0]            offset_q;
    logic [DATA_WIDTH-1:0] ld_data;

    function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    assign offset = alu_resultm[1:0];

    // Access decode, alignment check and store lane formatting.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load       = (wb_ctrm == 2'b01) && !mem_wem;
        access     = mem_wem || load;
        misaligned = 1'b0;
        st_be      = 4'b1111;
        st_wdata   = rd2_turem;
        case (opm[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
        if (mem_wem) begin
            case (opm)
                3'b000: begin
                    st_be    = 4'b0001 << offset;
                    st_wdata = {4{rd2_turem[7:0]}};
                end
                3'b001: begin
                    st_be    = 4'b0011 << {offset[1], 1'b0};
                    st_wdata = {2{rd2_turem[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = rd2_turem;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: if (access && !misaligned) begin
                start      = 1'b1;
                state_next = REQ;
            end
            REQ:     if (dmem.ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
            op_q     <= 3'b000;
            offset_q <= 2'b00;
            ld_data  <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                addr_q   <= {alu_resultm[ADDR_WIDTH-1:2], 2'b00};
                we_q     <= mem_wem;
                wdata_q  <= st_wdata;
                be_q     <= st_be;
                op_q     <= opm;
                offset_q <= offset;
            end
            // Only loads refresh ld_data; a store leaves the last loaded value in place.
            if (state == REQ && dmem.ready && !we_q)
                ld_data <= extend_load(op_q, offset_q, dmem.rdata);
        end
    end

    assign dmem.req   = (state == REQ);
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    assign misalign_exc = access && misaligned;
    assign stall_mem    = access && !misaligned && (state != RESP);
    assign reg_wew      = reg_wem && !misalign_exc && !stall_mem;
    assign mem_rdataw   = (state == RESP) ? ld_data : '0;

    assign rdw         = rdm;
    assign pcnw        = pcnm;
    assign alu_resultw = alu_resultm;
    assign wb_ctrw     = wb_ctrm;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I core. It consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores over a req/ready bus.
- It aligns store data and byte enables, then sign- or zero-extends load data.
- It stalls the upstream pipeline while an access is outstanding.
- It presents writeback-bound signals to the MEM/WB register.

Parameters:
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, address and PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- reg_wem  in  1  register write enable from EX/MEM.
- opm  in  3  funct3 of the memory op.
- mem_wem  in  1  store enable.
- rdm  in  5  destination register.
- pcnm  in  ADDR_WIDTH  PC+4.
- alu_resultm  in  DATA_WIDTH  effective address / ALU result.
- rd2_turem  in  DATA_WIDTH  store data, already forwarded.
- wb_ctrm  in  2  writeback select; 2'b01 means load data.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are 0.
- dmem_wdata  out  DATA_WIDTH  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  bus completion strobe.
- dmem_rdata  in  DATA_WIDTH  read word, valid when dmem_ready is high.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- misalign_exc  out  1  misaligned access flag.
- reg_wew  out  1  register write enable toward MEM/WB.
- rdw  out  5  destination register, pass-through.
- pcnw  out  ADDR_WIDTH  PC+4, pass-through.
- alu_resultw  out  DATA_WIDTH  ALU result, pass-through.
- mem_rdataw  out  DATA_WIDTH  extended load data.
- wb_ctrw  out  2  writeback select, pass-through.

Behaviour:
- Access decode:
  - load = (wb_ctrm == 2'b01) and !mem_wem.
  - access = mem_wem or load.
  - A bubble (all-zero EX/MEM contents) is not an access.
- Misalignment (combinational):
  - Halfword (opm[1:0] = 01) with addr[0] = 1 is misaligned.
  - Word (opm[1:0] = 10) with addr[1:0] != 0 is misaligned.
  - misalign_exc = access and misaligned.
  - When it is set: no bus request, stall_mem = 0, reg_wew = 0.
- FSM states: IDLE, REQ, RESP. Reset → IDLE.
  - IDLE: if access and not misaligned, capture address, we, wdata and be into registers and go to REQ.
  - REQ: dmem_req = 1 and all bus outputs held stable. On dmem_ready: if load, capture the extended dmem_rdata into ld_data; go to RESP. With no ready, stay in REQ indefinitely.
  - RESP: one cycle, then unconditionally IDLE. The upstream advances at the end of this cycle.
- stall_mem = access and not misaligned and state != RESP. It is combinational.
  - Minimum access latency with dmem_ready high on the first REQ cycle: 3 cycles (IDLE, REQ, RESP).
  - A new access presented directly after RESP starts from IDLE in the following cycle with no bubble.
- Store formatting:
  - SB (opm 000): be = 0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH (001): be = 0011 << {addr[1], 1'b0}; wdata = halfword replicated ×2.
  - SW (010) and all other opm values: be = 1111; wdata as-is.
- Load extraction: the lane is selected by addr[1:0].
  - LB (000): sign-extend the byte.
  - LH (001): sign-extend the halfword.
  - LBU (100): zero-extend the byte.
  - LHU (101): zero-extend the halfword.
  - LW (010) and all other values: full word.
- Loads drive dmem_be = 1111; dmem_we = 0.
- Outputs toward MEM/WB:
  - mem_rdataw = ld_data while in RESP, else 0.
  - reg_wew = reg_wem and !misalign_exc and !stall_mem.
  - Other signals are combinational pass-through.
- Reset values: state IDLE, ld_data 0, captured bus registers 0.
  - Hence dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0, mem_rdataw = 0.
- Reset mid-access (REQ or RESP): next cycle state is IDLE and dmem_req = 0; any pending ready is ignored.
- dmem_ready asserted while in IDLE or RESP is ignored.

Test Plan:
- SW: addr 0x0000_1004, data 0xDEAD_BEEF, ready on the first REQ cycle.
  → Bus shows addr 0x1004, be 1111, wdata 0xDEADBEEF, we 1.
  → stall_mem high for 2 cycles, low in RESP; reg_wew 0.
- LB: addr 0x2003, rdata 0x80FF_7F01, ready after 3 wait cycles.
  → dmem_req high for 4 cycles with the bus held stable.
  → mem_rdataw = 0xFFFF_FF80 in RESP.
  → LBU on the same stimulus → 0x0000_0080.
- SH: addr 0x3002, data 0x0000_ABCD.
  → be 1100, wdata 0xABCD_ABCD.
  → LHU at addr 0x3002 with rdata 0xABCD_0000 → 0x0000_ABCD.
- Misaligned LW: addr 0x4001 with reg_wem = 1.
  → misalign_exc 1, dmem_req never asserted, stall_mem 0, reg_wew 0.
- Back-to-back LW then SW, both ready on the first cycle.
  → Second request begins the cycle after the first RESP.
  → Each access stalls for 2 cycles; no lost or duplicated requests.
- rst asserted during REQ while ready is held low.
  → Next cycle: dmem_req 0, stall_mem follows the fresh decode, mem_rdataw 0.
  → A later dmem_ready pulse has no effect.
